// File: rtl/io_pkg.sv
// Shared constants for the CPU IO responder: register offsets and bus widths.
package io_pkg;

    localparam logic [7:0] LED_LO_OFS = 8'h60;
    localparam logic [7:0] LED_HI_OFS = 8'h62;
    localparam logic [7:0] SW_LO_OFS  = 8'h70;
    localparam logic [7:0] SW_HI_OFS  = 8'h72;

    localparam int LED_W     = 24;
    localparam int SW_W      = 24;
    localparam int IO_DATA_W = 16;

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises a raw switch vector and commits it only after it has been
// stable for DEBOUNCE_CYCLES consecutive cycles; pulses sw_changed on commit.
module switch_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int WIDTH           = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] debounced,
    output logic             sw_changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_sw;
    logic [WIDTH-1:0]                  cand;
    logic [CNT_W-1:0]                  cnt;

    assign sync_sw = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], switch_in};
        end
    end

    // Any change restarts the window; once saturated the counter holds so a
    // long-stable vector never re-commits or wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '0;
            cnt        <= '0;
            debounced  <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (sync_sw != cand) begin
                cand <= sync_sw;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                if (cand != debounced) begin
                    debounced  <= cand;
                    sw_changed <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Peripheral end of the CPU IO path: LED registers, debounced switches and a
// zero-latency read mux back to the CPU.
module io_responder
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 LEDCtrl,
    input  logic                 SwitchCtrl,
    input  logic                 ioWrite,
    input  logic                 ioRead,
    input  logic [7:0]           addr_low,
    input  logic [31:0]          write_data,
    output logic [IO_DATA_W-1:0] io_rdata,
    input  logic [SW_W-1:0]      switch_in,
    output logic [LED_W-1:0]     led_out,
    output logic                 sw_changed
);

    logic [SW_W-1:0] sw_debounced;
    logic            unused_wdata_hi;

    assign unused_wdata_hi = ^write_data[31:16];

    switch_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .WIDTH           (SW_W)
    ) u_debouncer (
        .clk        (clk),
        .rst_n      (rst_n),
        .switch_in  (switch_in),
        .debounced  (sw_debounced),
        .sw_changed (sw_changed)
    );

    // LED writes ignore SwitchCtrl entirely, so an illegal dual select still stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else if (LEDCtrl && ioWrite) begin
            case (addr_low)
                LED_LO_OFS: led_out[15:0]  <= write_data[15:0];
                LED_HI_OFS: led_out[23:16] <= write_data[7:0];
                default:    ;
            endcase
        end
    end

    // The CPU samples in the same cycle, so reads are purely combinational;
    // switch reads win if both selects are asserted.
    always_comb begin
        io_rdata = '0;
        if (SwitchCtrl && ioRead) begin
            case (addr_low)
                SW_LO_OFS: io_rdata = sw_debounced[15:0];
                SW_HI_OFS: io_rdata = {8'h00, sw_debounced[23:16]};
                default:   io_rdata = '0;
            endcase
        end else if (LEDCtrl && ioRead) begin
            case (addr_low)
                LED_LO_OFS: io_rdata = led_out[15:0];
                LED_HI_OFS: io_rdata = {8'h00, led_out[23:16]};
                default:    io_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: LED writes/readback, switch debounce,
// glitch rejection, address decode and asynchronous reset.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        LEDCtrl;
    logic        SwitchCtrl;
    logic        ioWrite;
    logic        ioRead;
    logic [7:0]  addr_low;
    logic [31:0] write_data;
    logic [15:0] io_rdata;
    logic [23:0] switch_in;
    logic [23:0] led_out;
    logic        sw_changed;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    io_responder #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LEDCtrl    (LEDCtrl),
        .SwitchCtrl (SwitchCtrl),
        .ioWrite    (ioWrite),
        .ioRead     (ioRead),
        .addr_low   (addr_low),
        .write_data (write_data),
        .io_rdata   (io_rdata),
        .switch_in  (switch_in),
        .led_out    (led_out),
        .sw_changed (sw_changed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickCount(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (sw_changed) pulses++;
        end
    endtask

    task automatic applyStimulus(input logic led_sel, input logic sw_sel,
                                 input logic wr, input logic rd,
                                 input logic [7:0] a, input logic [31:0] wd);
        LEDCtrl    = led_sel;
        SwitchCtrl = sw_sel;
        ioWrite    = wr;
        ioRead     = rd;
        addr_low   = a;
        write_data = wd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        switch_in = 24'hABCDEF;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0);
        tick();
        tick();
        checkOutput("reset_led", led_out, 24'h0);
        checkOutput("reset_rdata", 24'(io_rdata), 24'h0);
        checkOutput("reset_pulse", 24'(sw_changed), 24'h0);

        // Release and count the 2+4+1 cycle commit window
        rst_n  = 1'b1;
        pulses = 0;
        tickCount(6);
        checkOutput("pulse_before_window", 24'(pulses), 24'h0);
        checkOutput("sw_lo_before_window", 24'(io_rdata), 24'h0);
        tick();
        checkOutput("pulse_at_window", 24'(sw_changed), 24'h1);
        checkOutput("sw_lo_commit", 24'(io_rdata), 24'h00CDEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h72, 32'h0);
        checkOutput("sw_hi_commit", 24'(io_rdata), 24'h0000AB);
        pulses = 0;
        tickCount(4);
        checkOutput("single_pulse", 24'(pulses), 24'h0);

        // LED writes and readback
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h60, 32'h1234_5678);
        tick();
        checkOutput("led_lo_write", led_out, 24'h005678);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h62, 32'h0000_FF9A);
        tick();
        checkOutput("led_hi_write", led_out, 24'h9A5678);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h62, 32'h0);
        checkOutput("led_hi_read", 24'(io_rdata), 24'h00009A);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 32'h0);
        checkOutput("led_lo_read", 24'(io_rdata), 24'h005678);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h60, 32'hFFFF);
        tick();
        checkOutput("led_hold", led_out, 24'h9A5678);

        // Switch-select writes and unmapped offsets have no effect
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h60, 32'hFFFF);
        tick();
        checkOutput("sw_ctrl_write", led_out, 24'h9A5678);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h64, 32'hFFFF);
        tick();
        checkOutput("bad_ofs_write", led_out, 24'h9A5678);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h64, 32'h0);
        checkOutput("bad_ofs_read_64", 24'(io_rdata), 24'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h74, 32'h0);
        checkOutput("bad_ofs_read_74", 24'(io_rdata), 24'h0);

        // Illegal dual select: switch read wins, LED write still lands
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0);
        checkOutput("dual_sel_read", 24'(io_rdata), 24'h00CDEF);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h60, 32'h0000_0BAD);
        tick();
        checkOutput("dual_sel_write", led_out, 24'h9A0BAD);

        // Same-cycle read and write of LED_LO
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h60, 32'h1111);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h60, 32'h2222);
        checkOutput("rw_same_old", 24'(io_rdata), 24'h001111);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 32'h0);
        checkOutput("rw_same_new", 24'(io_rdata), 24'h002222);
        checkOutput("rw_same_led", led_out, 24'h9A2222);

        // Settle switches to zero, then a 3-cycle glitch must be rejected
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0);
        switch_in = 24'h000000;
        pulses    = 0;
        tickCount(10);
        checkOutput("settle_zero_pulse", 24'(pulses), 24'h1);
        checkOutput("settle_zero_read", 24'(io_rdata), 24'h0);
        pulses    = 0;
        switch_in = 24'h000001;
        tickCount(3);
        switch_in = 24'h000000;
        tickCount(12);
        checkOutput("glitch_no_pulse", 24'(pulses), 24'h0);
        checkOutput("glitch_read", 24'(io_rdata), 24'h0);

        // Asynchronous reset in the middle of a debounce window
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h60, 32'hFFFF);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h62, 32'h00FF);
        tick();
        checkOutput("led_all_on", led_out, 24'hFFFFFF);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0);
        switch_in = 24'h5A5A5A;
        pulses    = 0;
        tickCount(4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_led", led_out, 24'h0);
        checkOutput("async_reset_pulse", 24'(sw_changed), 24'h0);
        tickCount(2);
        checkOutput("reset_hold_pulse", 24'(pulses), 24'h0);
        checkOutput("reset_hold_read", 24'(io_rdata), 24'h0);
        rst_n  = 1'b1;
        tickCount(6);
        checkOutput("rewindow_no_pulse", 24'(pulses), 24'h0);
        checkOutput("rewindow_read", 24'(io_rdata), 24'h0);
        tick();
        checkOutput("rewindow_pulse", 24'(sw_changed), 24'h1);
        checkOutput("rewindow_commit", 24'(io_rdata), 24'h005A5A);
        checkOutput("rewindow_led", led_out, 24'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Peripheral-side end of the CPU IO path.
- Accepts the LED/switch chip selects, low address bits and the 32-bit store data produced by the CPU memory/IO mux, and holds the 24 board LEDs in registers.
- Synchronises and debounces the 24 board switches, and returns 16-bit read data on the io_rdata bus, which the CPU side sign-extends.
- Sits between the CPU top level and the board pins.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the switch synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a switch vector is committed (10 ms at 100 MHz). Benches set it to 4.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- LEDCtrl  in  1  LED chip select from CPU side
- SwitchCtrl  in  1  switch chip select from CPU side
- ioWrite  in  1  IO write strobe, one cycle per store
- ioRead  in  1  IO read enable
- addr_low  in  8  io address bits [7:0]
- write_data  in  32  store data; only bits [15:0] are used
- io_rdata  out  16  read data to CPU side
- switch_in  in  24  raw asynchronous board switches
- led_out  out  24  board LEDs
- sw_changed  out  1  one-cycle pulse when the debounced switch vector changes

Behaviour:
- Reset (rst_n low, asynchronous):
  - led_out = 0, sw_changed = 0, debounced vector = 0, debounce counter = 0, synchroniser chain = 0.
  - io_rdata therefore reads 0.
- Address map (addr_low):
  - 0x60 = LED_LO (led[15:0])
  - 0x62 = LED_HI (led[23:16] in write_data[7:0])
  - 0x70 = SW_LO
  - 0x72 = SW_HI
  - Any other offset: writes ignored, reads return 0.
- LED write:
  - Occurs on the rising edge where LEDCtrl & ioWrite = 1.
  - LED_LO loads led[15:0] <= write_data[15:0].
  - LED_HI loads led[23:16] <= write_data[7:0]; write_data[15:8] is ignored.
  - The new value is visible on led_out the cycle after the edge (latency 1).
  - Without the strobe, LEDs hold their value.
- Read path: combinational, 0 latency, because the CPU samples in the same cycle.
  - SwitchCtrl & ioRead, SW_LO -> debounced[15:0]
  - SwitchCtrl & ioRead, SW_HI -> {8'h00, debounced[23:16]}
  - LEDCtrl & ioRead, LED_LO -> led[15:0]
  - LEDCtrl & ioRead, LED_HI -> {8'h00, led[23:16]}
  - Otherwise io_rdata = 16'h0000. The bus is never driven to Z.
- Synchroniser: switch_in passes through SYNC_STAGES flops to produce sync_sw.
- Debounce, whole-vector:
  - Keep cand = last sampled sync_sw.
  - If sync_sw != cand: cand <= sync_sw, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1 and cand != debounced: debounced <= cand, sw_changed <= 1 for one cycle, cnt holds.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt++.
  - The counter saturates and never wraps.
  - Latency from a clean switch edge to the debounced update is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Glitch shorter than DEBOUNCE_CYCLES: counter restarts, debounced is unchanged, no pulse.
- Simultaneous read and write of the same LED register in one cycle: io_rdata returns the old value; the new value is visible next cycle.
- LEDCtrl and SwitchCtrl both high is illegal on the CPU side. If it occurs, the switch read has priority for io_rdata; the LED write still happens if ioWrite is high.
- ioWrite with SwitchCtrl: no effect, because switches are read-only.
- Reset asserted mid-debounce: all state is cleared. After release, the switches must be stable for the full window again before they are committed.

Decomposition:
- Package io_pkg holds:
  - constants LED_LO_OFS = 8'h60, LED_HI_OFS = 8'h62, SW_LO_OFS = 8'h70, SW_HI_OFS = 8'h72;
  - LED_W = 24, SW_W = 24, IO_DATA_W = 16.
- Sub-module switch_debouncer (parameters SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W, WIDTH) contains the synchroniser, counter and sw_changed pulse.
- The LED registers and read mux stay in the top level.

Test Plan:
- Reset release with switch_in = 24'hABCDEF held: io_rdata = 0 before the window. After 2+4+1 cycles, SW_LO read = 16'hCDEF, SW_HI read = 16'h00AB, and sw_changed pulses exactly once.
- Write 32'h1234_5678 to 0x60, then 32'h0000_FF9A to 0x62 (ioWrite + LEDCtrl, one cycle each) -> led_out = 24'h9A5678 one cycle after the second edge; readback LED_HI = 16'h009A.
- Switch glitch: switch_in toggles 0x000001 for 3 cycles then returns to 0 -> debounced unchanged, no sw_changed pulse.
- Write to 0x64 with data 0xFFFF -> led_out unchanged; read of 0x64 or 0x74 returns 0.
- Assert rst_n low asynchronously (between clock edges) with led_out = 24'hFFFFFF and a debounce in progress -> led_out = 0 immediately, no sw_changed pulse. After release the full window is required again.
- Same-cycle read and write of LED_LO (old value 0x1111, new value 0x2222) -> io_rdata = 16'h1111 that cycle, 16'h2222 the next cycle.
